// File: rtl/user_input_pkg.sv
// Shared scan-code constants, parser states and the default key map for the PS/2 user-input block.
package user_input_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    localparam logic [8:0] KC_LEFT   = 9'h16B;
    localparam logic [8:0] KC_RIGHT  = 9'h174;
    localparam logic [8:0] KC_DOWN   = 9'h172;
    localparam logic [8:0] KC_ROTATE = 9'h175;
    localparam logic [8:0] KC_DROP   = 9'h029;
    localparam logic [8:0] KC_NONE   = 9'h000;

    localparam int DEF_KEY_CNT = 8;

    // Slot 0 sits in the least significant 9 bits.
    localparam logic [DEF_KEY_CNT*9-1:0] DEF_KEY_CODES = {
        KC_NONE, KC_NONE, KC_NONE, KC_DROP, KC_ROTATE, KC_DOWN, KC_RIGHT, KC_LEFT
    };

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } ps_state_e;

    typedef logic [$clog2(DEF_KEY_CNT)-1:0] user_event_t;

endpackage

// File: rtl/event_fifo_fwft.sv
// First-word-fall-through event queue; head is valid the cycle after the push that filled an empty queue.
// A push into a full queue is dropped and latches overflow_o, unless a pop frees the slot in the same cycle.
module event_fifo_fwft #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, pop_ok, push_ok;

    always_comb begin
        full     = (count_q == CNTW'(DEPTH));
        empty_o  = (count_q == '0);
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ovf_d    = ovf_q || (push_i && !push_ok);
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        dout_o     = empty_o ? '0 : mem_q[rd_ptr_q];
        overflow_o = ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/user_input_repeat.sv
// PS/2 make/break decoder with per-key hold tracking and auto-repeat, feeding a FWFT event queue.
// Byte strobe at t -> event visible at t+3; events pushed into a full queue are dropped (sticky overflow_o).
module user_input_repeat
    import user_input_pkg::*;
#(
    parameter int                   KEY_CNT          = DEF_KEY_CNT,
    parameter logic [KEY_CNT*9-1:0] KEY_CODES        = DEF_KEY_CODES,
    parameter int                   FIFO_DEPTH       = 8,
    parameter int                   REPEAT_DELAY_CYC = 6_250_000,
    parameter int                   REPEAT_RATE_CYC  = 2_500_000,
    localparam int                  KW               = $clog2(KEY_CNT)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [7:0]         ps2_key_data_i,
    input  logic               ps2_key_data_en_i,
    input  logic [KEY_CNT-1:0] repeat_en_i,
    input  logic               user_event_rd_req_i,
    output logic [KW-1:0]      user_event_o,
    output logic               user_event_ready_o,
    output logic [KEY_CNT-1:0] held_o,
    output logic               overflow_o
);

    localparam int CMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE_CYC - 1);

    ps_state_e state_q, state_d;
    logic       code_vld_q, code_vld_d;
    logic       code_brk_q, code_brk_d;
    logic [8:0] code_q, code_d;

    logic          match_vld_q, match_vld_d;
    logic          match_brk_q, match_brk_d;
    logic [KW-1:0] match_idx_q, match_idx_d;

    logic [KEY_CNT-1:0]         held_q, held_d;
    logic [KEY_CNT-1:0]         pend_q, pend_d;
    logic [KEY_CNT-1:0][CW-1:0] cnt_q, cnt_d;

    logic [KEY_CNT-1:0] expire, rep_req, rep_grant;
    logic               make_new, push_vld, fifo_empty;
    logic [KW-1:0]      push_idx;

    always_comb begin
        state_d    = state_q;
        code_vld_d = 1'b0;
        code_brk_d = 1'b0;
        code_d     = code_q;
        if (ps2_key_data_en_i) begin
            unique case (state_q)
                PS_IDLE: begin
                    if (ps2_key_data_i == SC_E0) begin
                        state_d = PS_EXT;
                    end else if (ps2_key_data_i == SC_F0) begin
                        state_d = PS_BRK;
                    end else begin
                        code_vld_d = 1'b1;
                        code_d     = {1'b0, ps2_key_data_i};
                    end
                end
                PS_EXT: begin
                    if (ps2_key_data_i == SC_F0) begin
                        state_d = PS_EXT_BRK;
                    end else if (ps2_key_data_i != SC_E0) begin
                        state_d    = PS_IDLE;
                        code_vld_d = 1'b1;
                        code_d     = {1'b1, ps2_key_data_i};
                    end
                end
                PS_BRK: begin
                    state_d    = PS_IDLE;
                    code_vld_d = 1'b1;
                    code_brk_d = 1'b1;
                    code_d     = {1'b0, ps2_key_data_i};
                end
                PS_EXT_BRK: begin
                    state_d    = PS_IDLE;
                    code_vld_d = 1'b1;
                    code_brk_d = 1'b1;
                    code_d     = {1'b1, ps2_key_data_i};
                end
                default: state_d = PS_IDLE;
            endcase
        end
    end

    // Descending scan so the lowest matching slot wins; empty slots never match.
    always_comb begin
        match_vld_d = 1'b0;
        match_idx_d = '0;
        match_brk_d = code_brk_q;
        for (int i = KEY_CNT - 1; i >= 0; i--) begin
            if (code_vld_q && KEY_CODES[i*9 +: 9] != KC_NONE && KEY_CODES[i*9 +: 9] == code_q) begin
                match_vld_d = 1'b1;
                match_idx_d = KW'(i);
            end
        end
    end

    always_comb begin
        expire = '0;
        for (int i = 0; i < KEY_CNT; i++) begin
            expire[i] = held_q[i] && repeat_en_i[i] && (cnt_q[i] == '0);
        end
        rep_req  = pend_q | expire;
        make_new = match_vld_q && !match_brk_q && !held_q[match_idx_q];
    end

    // A fresh make outranks repeats; ungranted repeat requests stay pending.
    always_comb begin
        push_vld  = 1'b0;
        push_idx  = '0;
        rep_grant = '0;
        if (make_new) begin
            push_vld = 1'b1;
            push_idx = match_idx_q;
        end else if (|rep_req) begin
            push_vld = 1'b1;
            for (int i = KEY_CNT - 1; i >= 0; i--) begin
                if (rep_req[i]) begin
                    push_idx = KW'(i);
                end
            end
            rep_grant[push_idx] = 1'b1;
        end
    end

    always_comb begin
        held_d = held_q;
        pend_d = rep_req & ~rep_grant;
        cnt_d  = cnt_q;
        for (int i = 0; i < KEY_CNT; i++) begin
            if (held_q[i] && repeat_en_i[i]) begin
                cnt_d[i] = (cnt_q[i] == '0) ? RATE_LD : cnt_q[i] - CW'(1);
            end
            if (match_vld_q && match_idx_q == KW'(i)) begin
                if (match_brk_q) begin
                    held_d[i] = 1'b0;
                    pend_d[i] = 1'b0;
                end else if (!held_q[i]) begin
                    held_d[i] = 1'b1;
                    cnt_d[i]  = DELAY_LD;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= PS_IDLE;
            code_vld_q  <= 1'b0;
            code_brk_q  <= 1'b0;
            code_q      <= '0;
            match_vld_q <= 1'b0;
            match_brk_q <= 1'b0;
            match_idx_q <= '0;
            held_q      <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            code_vld_q  <= code_vld_d;
            code_brk_q  <= code_brk_d;
            code_q      <= code_d;
            match_vld_q <= match_vld_d;
            match_brk_q <= match_brk_d;
            match_idx_q <= match_idx_d;
            held_q      <= held_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
        end
    end

    event_fifo_fwft #(
        .WIDTH (KW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (push_vld),
        .din_i      (push_idx),
        .pop_i      (user_event_rd_req_i),
        .dout_o     (user_event_o),
        .empty_o    (fifo_empty),
        .overflow_o (overflow_o)
    );

    assign user_event_ready_o = !fifo_empty;
    assign held_o             = held_q;

endmodule

// File: tb/tb_user_input_repeat.sv
// Directed bench: decode table, repeat timing, push arbitration, overflow and mid-operation reset.
module tb_user_input_repeat;
    import user_input_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        den = 1'b0;
    logic [7:0]  ren = 8'h00;
    logic        rd = 1'b0;
    user_event_t ev;
    logic        ready;
    logic [7:0]  held;
    logic        ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int log_cyc[$];
    int log_idx[$];

    user_input_repeat #(
        .KEY_CNT          (8),
        .FIFO_DEPTH       (4),
        .REPEAT_DELAY_CYC (10),
        .REPEAT_RATE_CYC  (4)
    ) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .ps2_key_data_i      (data),
        .ps2_key_data_en_i   (den),
        .repeat_en_i         (ren),
        .user_event_rd_req_i (rd),
        .user_event_o        (ev),
        .user_event_ready_o  (ready),
        .held_o              (held),
        .overflow_o          (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rd && ready) begin
            log_cyc.push_back(cyc);
            log_idx.push_back(int'(ev));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [23:0] seq;
        int          n;
        bit          ev;
        int          idx;
        logic [7:0]  held;
    } vec_t;

    vec_t vt[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        den  = 1'b1;
        tick();
        den  = 1'b0;
    endtask

    task automatic send_seq(input logic [23:0] s, input int n, output int c);
        c = cyc;
        for (int k = 0; k < n; k++) begin
            c = cyc;
            send(s[23-8*k -: 8]);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int c;
        int e;
        int base;
        int exp_c[4];
        int exp_i[3];

        vt[0]  = '{24'h6B0000, 1, 1'b0, 0, 8'h00};
        vt[1]  = '{24'hE06B00, 2, 1'b1, 0, 8'h01};
        vt[2]  = '{24'hE06B00, 2, 1'b0, 0, 8'h01};
        vt[3]  = '{24'hE0F06B, 3, 1'b0, 0, 8'h00};
        vt[4]  = '{24'h290000, 1, 1'b1, 4, 8'h10};
        vt[5]  = '{24'hE0E074, 3, 1'b1, 1, 8'h12};
        vt[6]  = '{24'hF02900, 2, 1'b0, 0, 8'h02};
        vt[7]  = '{24'hE0F074, 3, 1'b0, 0, 8'h00};
        vt[8]  = '{24'h000000, 1, 1'b0, 0, 8'h00};
        vt[9]  = '{24'hE07200, 2, 1'b1, 2, 8'h04};
        vt[10] = '{24'hF07200, 2, 1'b0, 0, 8'h04};
        vt[11] = '{24'hE0F072, 3, 1'b0, 0, 8'h00};
        vt[12] = '{24'hE11400, 2, 1'b0, 0, 8'h00};
        vt[13] = '{24'hE07500, 2, 1'b1, 3, 8'h08};
        vt[14] = '{24'hE0F075, 3, 1'b0, 0, 8'h00};

        tick();
        tick();
        check("reset_ready", int'(ready), 0);
        check("reset_held", int'(held), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_event", int'(ev), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Decode table: latency, event index and held map per byte sequence.
        for (int v = 0; v < 15; v++) begin
            send_seq(vt[v].seq, vt[v].n, c);
            wait_until(c + 2);
            check($sformatf("vec%0d_early", v), int'(ready), 0);
            wait_until(c + 3);
            check($sformatf("vec%0d_ready", v), int'(ready), int'(vt[v].ev));
            if (vt[v].ev) check($sformatf("vec%0d_idx", v), int'(ev), vt[v].idx);
            check($sformatf("vec%0d_held", v), int'(held), int'(vt[v].held));
            rd = 1'b1;
            tick();
            rd = 1'b0;
            check($sformatf("vec%0d_drained", v), int'(ready), 0);
            repeat (2) tick();
        end

        // Auto-repeat timing on the drop key: make, +10, then every 4 until break.
        rd   = 1'b1;
        ren  = 8'h10;
        base = log_idx.size();
        c    = cyc;
        send(8'h29);
        wait_until(c + 20);
        send(8'hF0);
        send(8'h29);
        wait_until(c + 40);
        exp_c[0] = c + 3;
        exp_c[1] = c + 13;
        exp_c[2] = c + 17;
        exp_c[3] = c + 21;
        check("rep_count", log_idx.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < log_idx.size()) begin
                check($sformatf("rep%0d_idx", k), log_idx[base+k], 4);
                check($sformatf("rep%0d_cycle", k), log_cyc[base+k], exp_c[k]);
            end
        end
        check("rep_held_after_break", int'(held), 0);
        ren = 8'h00;

        // Same-cycle make of key 2 and repeat expiry of keys 0 and 1.
        send_seq(24'hE06B00, 2, c);
        send_seq(24'hE07400, 2, c);
        repeat (6) tick();
        base = log_idx.size();
        e    = cyc;
        ren  = 8'h03;
        wait_until(e + 6);
        send(8'hE0);
        send(8'h72);
        wait_until(e + 11);
        ren = 8'h00;
        wait_until(e + 20);
        exp_i[0] = 2;
        exp_i[1] = 0;
        exp_i[2] = 1;
        check("arb_count", log_idx.size() - base, 3);
        for (int k = 0; k < 3; k++) begin
            if (base + k < log_idx.size()) begin
                check($sformatf("arb%0d_idx", k), log_idx[base+k], exp_i[k]);
                check($sformatf("arb%0d_cycle", k), log_cyc[base+k], e + 10 + k);
            end
        end
        rd = 1'b0;
        send_seq(24'hE0F06B, 3, c);
        send_seq(24'hE0F074, 3, c);
        send_seq(24'hE0F072, 3, c);
        repeat (5) tick();
        check("arb_held_cleared", int'(held), 0);
        check("arb_queue_empty", int'(ready), 0);

        // Overflow: five makes into a four-deep queue with no reads.
        check("ovf_before", int'(ovf), 0);
        send_seq(24'hE06B00, 2, c);
        send_seq(24'hE07400, 2, c);
        send_seq(24'hE07200, 2, c);
        send_seq(24'hE07500, 2, c);
        repeat (4) tick();
        check("ovf_full_no_drop", int'(ovf), 0);
        send_seq(24'h290000, 1, c);
        repeat (4) tick();
        check("ovf_set", int'(ovf), 1);
        check("ovf_held", int'(held), 8'h1F);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_rd%0d_ready", k), int'(ready), 1);
            check($sformatf("ovf_rd%0d_idx", k), int'(ev), k);
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        check("ovf_drained", int'(ready), 0);
        check("ovf_sticky", int'(ovf), 1);
        send_seq(24'hE0F06B, 3, c);
        send_seq(24'hE0F074, 3, c);
        send_seq(24'hE0F072, 3, c);
        send_seq(24'hE0F075, 3, c);
        send_seq(24'hF02900, 2, c);
        repeat (5) tick();

        // Reset with queued events and a dangling E0 prefix.
        send_seq(24'hE06B00, 2, c);
        send_seq(24'hE07400, 2, c);
        send_seq(24'hE07200, 2, c);
        repeat (4) tick();
        check("rst_pre_ready", int'(ready), 1);
        check("rst_pre_held", int'(held), 8'h07);
        send(8'hE0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_ready", int'(ready), 0);
        check("rst_held", int'(held), 0);
        check("rst_ovf", int'(ovf), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        c = cyc;
        send(8'h6B);
        wait_until(c + 4);
        check("rst_no_stale_ext_ready", int'(ready), 0);
        check("rst_no_stale_ext_held", int'(held), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
